// File: rtl/jstk_spi_reader_if.sv
// Bus bundle between the PmodJSTK reader and its joystick/consumer side.
// The master modport belongs to the reader. The slave modport belongs to the joystick model and the consumers.
interface jstk_spi_reader_if;
    logic [1:0]  leds;
    logic        miso;
    logic        sclk;
    logic        mosi;
    logic        ss;
    logic [10:0] x_val;
    logic [2:0]  btn;
    logic        ce;

    modport master (
        input  leds, miso,
        output sclk, mosi, ss, x_val, btn, ce
    );

    modport slave (
        output leds, miso,
        input  sclk, mosi, ss, x_val, btn, ce
    );
endinterface

// File: rtl/jstk_spi_reader.sv
// Polls a PmodJSTK over SPI mode 0 and converts the X reading into a servo pulse width in microseconds.
// Each completed five-byte transaction refreshes x_val/btn and raises a one-cycle ce.
module jstk_spi_reader #(
    parameter int CLK_DIV      = 50,
    parameter int SS_SETUP_CYC = 1500,
    parameter int BYTE_GAP_CYC = 1000,
    parameter int POLL_CYC     = 1000000,
    parameter int X_OFFSET     = 1000,
    parameter int X_MAX        = 2000
) (
    input  logic              clk,
    input  logic              rst,
    jstk_spi_reader_if.master bus
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, DONE} state_t;

    localparam int CNT_MAX = (SS_SETUP_CYC > BYTE_GAP_CYC)
                             ? ((SS_SETUP_CYC > CLK_DIV) ? SS_SETUP_CYC : CLK_DIV)
                             : ((BYTE_GAP_CYC > CLK_DIV) ? BYTE_GAP_CYC : CLK_DIV);
    localparam int CNT_W  = $clog2(CNT_MAX + 1);
    localparam int POLL_W = $clog2(POLL_CYC + 1);

    localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(SS_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(BYTE_GAP_CYC - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYC - 1);

    state_t            state_q, state_d;
    logic [POLL_W-1:0] pollCnt_q, pollCnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bitIdx_q, bitIdx_d;
    logic [2:0]        byteIdx_q, byteIdx_d;
    logic [1:0]        leds_q, leds_d;
    logic [7:0]        rxShift_q, rxShift_d;
    logic [9:0]        xRaw_q, xRaw_d;
    logic [2:0]        btnRaw_q, btnRaw_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              ss_q, ss_d;
    logic [10:0]       xVal_q, xVal_d;
    logic [2:0]        btn_q, btn_d;
    logic              ce_q, ce_d;
    logic              start;
    logic [10:0]       xSum;

    // Only byte 0 carries a command. Bytes 1-4 are zero padding that clocks out the remaining readings.
    function automatic logic txBit(input logic [2:0] byteIdx, input logic [2:0] bitIdx,
                                   input logic [1:0] ledsIn);
        logic [7:0] txByte;
        txByte = (byteIdx == 3'd0) ? {6'b100000, ledsIn} : 8'h00;
        return txByte[3'd7 - bitIdx];
    endfunction

    assign start = (pollCnt_q == POLL_LAST);
    assign xSum  = 11'(X_OFFSET) + {1'b0, xRaw_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pollCnt_q <= '0;
            cnt_q     <= '0;
            bitIdx_q  <= '0;
            byteIdx_q <= '0;
            leds_q    <= '0;
            rxShift_q <= '0;
            xRaw_q    <= '0;
            btnRaw_q  <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ss_q      <= 1'b1;
            xVal_q    <= 11'd1500;
            btn_q     <= '0;
            ce_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pollCnt_q <= pollCnt_d;
            cnt_q     <= cnt_d;
            bitIdx_q  <= bitIdx_d;
            byteIdx_q <= byteIdx_d;
            leds_q    <= leds_d;
            rxShift_q <= rxShift_d;
            xRaw_q    <= xRaw_d;
            btnRaw_q  <= btnRaw_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ss_q      <= ss_d;
            xVal_q    <= xVal_d;
            btn_q     <= btn_d;
            ce_q      <= ce_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pollCnt_d = start ? '0 : pollCnt_q + 1'b1;
        cnt_d     = cnt_q;
        bitIdx_d  = bitIdx_q;
        byteIdx_d = byteIdx_q;
        leds_d    = leds_q;
        rxShift_d = rxShift_q;
        xRaw_d    = xRaw_q;
        btnRaw_d  = btnRaw_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ss_d      = ss_q;
        xVal_d    = xVal_q;
        btn_d     = btn_q;
        ce_d      = 1'b0;

        case (state_q)
            IDLE: begin
                ss_d   = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                if (start) begin
                    state_d   = SETUP;
                    ss_d      = 1'b0;
                    leds_d    = bus.leds;
                    cnt_d     = '0;
                    byteIdx_d = '0;
                    bitIdx_d  = '0;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d  = SHIFT;
                    cnt_d    = '0;
                    bitIdx_d = '0;
                    mosi_d   = txBit(byteIdx_q, 3'd0, leds_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q != HALF_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (!sclk_q) begin
                    cnt_d     = '0;
                    sclk_d    = 1'b1;
                    rxShift_d = {rxShift_q[6:0], bus.miso};
                end else begin
                    // A falling SCLK edge opens the next low phase, which is the only time mosi may change.
                    cnt_d  = '0;
                    sclk_d = 1'b0;
                    if (bitIdx_q != 3'd7) begin
                        bitIdx_d = bitIdx_q + 3'd1;
                        mosi_d   = txBit(byteIdx_q, bitIdx_q + 3'd1, leds_q);
                    end else begin
                        case (byteIdx_q)
                            3'd0:    xRaw_d[7:0] = rxShift_q;
                            3'd1:    xRaw_d[9:8] = rxShift_q[1:0];
                            3'd4:    btnRaw_d    = rxShift_q[2:0];
                            default: ;
                        endcase
                        if (byteIdx_q == 3'd4) begin
                            state_d = DONE;
                            ss_d    = 1'b1;
                        end else begin
                            state_d = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d   = SHIFT;
                    cnt_d     = '0;
                    bitIdx_d  = '0;
                    byteIdx_d = byteIdx_q + 3'd1;
                    mosi_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                ss_d    = 1'b1;
                mosi_d  = 1'b0;
                xVal_d  = (xSum > 11'(X_MAX)) ? 11'(X_MAX) : xSum;
                btn_d   = btnRaw_q;
                ce_d    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sclk  = sclk_q;
    assign bus.mosi  = mosi_q;
    assign bus.ss    = ss_q;
    assign bus.x_val = xVal_q;
    assign bus.btn   = btn_q;
    assign bus.ce    = ce_q;

endmodule

// File: tb/tb_jstk_spi_reader.sv
// Directed bench for jstk_spi_reader. It uses a PmodJSTK slave model, and a scoreboard of expected x_val/btn popped on each ce.
module tb_jstk_spi_reader;

    localparam int CLK_DIV      = 2;
    localparam int SS_SETUP_CYC = 4;
    localparam int BYTE_GAP_CYC = 3;
    localparam int POLL_CYC     = 200;
    localparam int X_OFFSET     = 1000;
    localparam int X_MAX        = 2000;
    localparam int TXN_CYC      = SS_SETUP_CYC + 80 * CLK_DIV + 4 * BYTE_GAP_CYC + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jstk_spi_reader_if bus();

    jstk_spi_reader #(
        .CLK_DIV      (CLK_DIV),
        .SS_SETUP_CYC (SS_SETUP_CYC),
        .BYTE_GAP_CYC (BYTE_GAP_CYC),
        .POLL_CYC     (POLL_CYC),
        .X_OFFSET     (X_OFFSET),
        .X_MAX        (X_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [10:0] xVal;
        logic [2:0]  btn;
    } exp_t;

    exp_t        expQ[$];
    exp_t        scbExp;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [39:0] stream = '0;
    logic [39:0] mosiStream = '0;
    int          sclkRise = 0;
    int          ceCnt = 0;
    int          ceCyc = 0;
    int          prevCeCyc = 0;
    int          ssFallCnt = 0;
    int          ssFallCyc = 0;
    int          mosiGlitch = 0;
    logic        prevSs = 1'b1;
    logic        prevSclk = 1'b0;
    logic        prevMosi = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Joystick model: the first bit appears at ss fall, and each following bit right after the SCLK rise that consumed the previous one.
    always @(negedge bus.ss or posedge bus.sclk) begin
        if (bus.sclk) begin
            mosiStream = {mosiStream[38:0], bus.mosi};
            sclkRise++;
            bus.miso = (sclkRise < 40) ? stream[6'(39 - sclkRise)] : 1'b0;
        end else begin
            sclkRise   = 0;
            mosiStream = '0;
            bus.miso   = stream[39];
        end
    end

    always @(negedge clk) begin
        if (prevSs && !bus.ss) begin
            ssFallCnt++;
            ssFallCyc = cyc;
        end
        if (prevSclk && bus.sclk && (bus.mosi !== prevMosi)) mosiGlitch++;
        if (bus.ce === 1'b1) begin
            ceCnt++;
            prevCeCyc = ceCyc;
            ceCyc     = cyc;
            if (expQ.size() == 0) begin
                checkOutput("ceUnexpected", 64'(bus.ce), 64'd0);
            end else begin
                scbExp = expQ.pop_front();
                checkOutput("xVal", 64'(bus.x_val), 64'(scbExp.xVal));
                checkOutput("btn", 64'(bus.btn), 64'(scbExp.btn));
            end
        end
        prevSs   = bus.ss;
        prevSclk = bus.sclk;
        prevMosi = bus.mosi;
    end

    // Loads the slave's reply with junk in the don't-care bits, sets the LEDs, and queues the result a completed poll must produce.
    task automatic applyStimulus(input int xRaw, input int yRaw, input logic [2:0] btnRaw,
                                 input logic [1:0] ledsIn, input bit expectDone);
        logic [9:0] x10;
        logic [9:0] y10;
        int         sum;
        exp_t       e;
        x10      = 10'(xRaw);
        y10      = 10'(yRaw);
        stream   = {x10[7:0], 6'b101101, x10[9:8], y10[7:0], 6'b010011, y10[9:8], 5'b10110, btnRaw};
        bus.leds = ledsIn;
        if (expectDone) begin
            sum    = X_OFFSET + xRaw;
            e.xVal = 11'((sum > X_MAX) ? X_MAX : sum);
            e.btn  = btnRaw;
            expQ.push_back(e);
        end
    endtask

    task automatic waitCe(input int bound, input string tag);
        int startCnt;
        int n;
        startCnt = ceCnt;
        n = 0;
        while (ceCnt == startCnt && n < bound) begin
            @(posedge clk);
            n++;
        end
        checkOutput(tag, 64'(ceCnt != startCnt), 64'd1);
    endtask

    task automatic waitSsFall(input int bound, input string tag);
        int startCnt;
        int n;
        startCnt = ssFallCnt;
        n = 0;
        while (ssFallCnt == startCnt && n < bound) begin
            @(posedge clk);
            n++;
        end
        checkOutput(tag, 64'(ssFallCnt != startCnt), 64'd1);
    endtask

    initial begin
        int relCyc;
        int firstFall;
        int ceBefore;
        int n;

        bus.leds = 2'b00;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstSs", 64'(bus.ss), 64'd1);
        checkOutput("rstSclk", 64'(bus.sclk), 64'd0);
        checkOutput("rstMosi", 64'(bus.mosi), 64'd0);
        checkOutput("rstXVal", 64'(bus.x_val), 64'd1500);
        checkOutput("rstBtn", 64'(bus.btn), 64'd0);
        checkOutput("rstCe", 64'(bus.ce), 64'd0);

        // X=512 with btn=5 and both LEDs on.
        applyStimulus(512, 300, 3'b101, 2'b11, 1'b1);
        rst    = 1'b0;
        relCyc = cyc;
        waitSsFall(POLL_CYC + 10, "ssFall1Seen");
        checkOutput("firstStartDelay", 64'(ssFallCyc - relCyc), 64'(POLL_CYC));
        firstFall = ssFallCyc;
        waitCe(TXN_CYC + 10, "ce1Seen");
        checkOutput("txnLatency", 64'(ceCyc - ssFallCyc), 64'(TXN_CYC));
        checkOutput("sclkRises", 64'(sclkRise), 64'd40);
        checkOutput("mosiBytes1", 64'(mosiStream), 64'h83_0000_0000);
        @(negedge clk);
        checkOutput("cePulseWidth", 64'(bus.ce), 64'd0);
        checkOutput("xValHeld", 64'(bus.x_val), 64'd1512);

        // X=1023 saturates at the ceiling.
        applyStimulus(1023, 5, 3'b010, 2'b00, 1'b1);
        waitSsFall(POLL_CYC, "ssFall2Seen");
        checkOutput("pollPeriod", 64'(ssFallCyc - firstFall), 64'(POLL_CYC));
        waitCe(TXN_CYC + 10, "ce2Seen");
        checkOutput("mosiBytes2", 64'(mosiStream), 64'h80_0000_0000);
        @(negedge clk);

        // X=0 gives the floor.
        applyStimulus(0, 1023, 3'b000, 2'b01, 1'b1);
        waitSsFall(POLL_CYC, "ssFall3Seen");
        waitCe(TXN_CYC + 10, "ce3Seen");
        checkOutput("mosiBytes3", 64'(mosiStream), 64'h81_0000_0000);
        @(negedge clk);

        // Identical data on the next poll still strobes ce.
        applyStimulus(0, 1023, 3'b000, 2'b01, 1'b1);
        waitCe(POLL_CYC + 10, "ce4Seen");
        checkOutput("ceSpacing", 64'(ceCyc - prevCeCyc), 64'(POLL_CYC));
        @(negedge clk);
        checkOutput("xValStable", 64'(bus.x_val), 64'd1000);
        checkOutput("mosiStable", 64'(mosiGlitch), 64'd0);

        // Abort a transaction during byte 2 with reset.
        applyStimulus(700, 0, 3'b111, 2'b10, 1'b0);
        waitSsFall(POLL_CYC + 10, "ssFall5Seen");
        n = 0;
        while (sclkRise < 18 && n < TXN_CYC) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reachedByte2", 64'(sclkRise >= 18), 64'd1);
        ceBefore = ceCnt;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abortSs", 64'(bus.ss), 64'd1);
        checkOutput("abortSclk", 64'(bus.sclk), 64'd0);
        checkOutput("abortXVal", 64'(bus.x_val), 64'd1500);
        checkOutput("abortCe", 64'(bus.ce), 64'd0);
        @(negedge clk);
        applyStimulus(300, 0, 3'b111, 2'b10, 1'b1);
        rst    = 1'b0;
        relCyc = cyc;
        waitSsFall(POLL_CYC + 10, "ssFall6Seen");
        checkOutput("restartDelay", 64'(ssFallCyc - relCyc), 64'(POLL_CYC));
        checkOutput("noCeAfterAbort", 64'(ceCnt - ceBefore), 64'd0);
        waitCe(TXN_CYC + 10, "ce6Seen");
        @(negedge clk);

        checkOutput("scoreboardEmpty", 64'(expQ.size()), 64'd0);
        $display("[TB] directed sequence complete");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
